fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- PA-RISC-style instruction fetch front end with a PC/nPC register pair and the IF/ID pipeline register.
- Sits directly upstream of instruction_memory: drives its byte address A and captures its 32-bit word I.
- Implements the delayed-branch (PC <- nPC) sequencing, stall, and nullify, then hands the fetched instruction and its PC to decode.

Parameters:
- ADDR_W, 8, width of instruction address (matches instruction_memory A).
- DATA_W, 32, instruction width (matches instruction_memory I).
- RESET_PC, 8'h00, PC value after reset; nPC resets to RESET_PC+4.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush or bubble.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall: hold PC, nPC and IF/ID.
- flush  in  1  nullify: load NOP_WORD into IF/ID, valid=0.
- br_taken  in  1  redirect nPC to br_target (delayed branch).
- br_target  in  ADDR_W  branch target byte address.
- halt  in  1  stop fetching until reset.
- A  out  ADDR_W  address to instruction_memory; equals PC register.
- I  in  DATA_W  instruction word from instruction_memory (combinational read).
- id_instr  out  DATA_W  IF/ID instruction.
- id_pc  out  ADDR_W  PC of id_instr.
- id_valid  out  1  id_instr is a real instruction.
- fetch_state  out  2  FSM state, for debug and verification.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. All state updates happen on the rising edge of clk.
- Reset, which has top priority:
  - PC=RESET_PC, nPC=RESET_PC+4.
  - id_instr=NOP_WORD, id_pc=0, id_valid=0.
  - FSM enters BOOT.
  - Reset asserted mid-operation discards any pending branch, stall or halt.
- FSM states: BOOT=0, RUN=1, HALTED=2.
  - BOOT: one bubble cycle. IF/ID is loaded with NOP and valid=0; PC/nPC are not advanced. BOOT moves to RUN unconditionally (stall ignored in BOOT).
  - RUN: normal fetch, below. A cycle with halt=1 and stall=0 moves RUN to HALTED. In that cycle the instruction at the current PC is still captured into IF/ID, and PC/nPC do not advance.
  - HALTED: PC/nPC/A are frozen. IF/ID loads NOP with valid=0 every cycle. Only reset leaves HALTED.
- RUN update, when stall=0:
  - PC <= nPC.
  - nPC <= br_taken ? {br_target[ADDR_W-1:2],2'b00} : nPC+4.
  - id_instr <= I, id_pc <= PC, id_valid <= 1.
- Delay slot: the instruction at old nPC is always fetched after a taken branch. The target is fetched one cycle later.
- Stall (RUN, stall=1):
  - PC, nPC, id_instr, id_pc and id_valid are all held.
  - br_taken is ignored; upstream must hold the request until stall deasserts.
  - halt is ignored.
- Flush (RUN):
  - id_instr <= NOP_WORD, id_valid <= 0, id_pc <= PC. Flush overrides stall for IF/ID only.
  - PC/nPC advance as normal unless stall=1.
  - flush together with br_taken (stall=0) is allowed: the redirect takes effect and IF/ID is nullified.
- Arithmetic:
  - nPC+4 is modulo 2^ADDR_W, so 8'hFC+4 wraps to 8'h00 with no flag.
  - br_target low two bits are forced to 0.
- A is the registered PC output with no combinational path from any input. Fetch latency is one cycle: A at edge n gives id_instr at edge n+1.
- fetch_state is the registered FSM state.

Decomposition:
- Shared package fetch_pkg holds:
  - the state encodings BOOT/RUN/HALTED,
  - NOP_WORD,
  - the instruction stride constant 4,
  - ADDR_W/DATA_W defaults, shared with instruction_memory.
- One natural sub-module: pc_npc_reg. It holds the PC/nPC pair, the increment/redirect mux and the hold enable. The IF/ID register and FSM stay in fetch_stage.

Test Plan:
- Bench setup: instruction_memory is instantiated with word at byte address k = 32'hA000_0000|k.
- Reset then free run: reset for 2 cycles.
  - Required: BOOT gives id_valid=0.
  - Then id_pc = 0,4,8,12 with id_instr = A0000000, A0000004, A0000008, A000000C, id_valid=1.
- Delayed branch: br_taken=1, br_target=8'h41 while PC=8.
  - Required id_pc sequence: 8, 12 (delay slot), 64 (8'h40, low bits cleared), 68.
- Stall: stall=1 for 3 cycles at PC=16.
  - Required: A=16 held, id_instr/id_pc frozen.
  - Release → id_pc 16 then 20, with no duplicate and no skip.
- Flush plus stall: flush=1, stall=1 in the same cycle.
  - Required: id_valid=0, id_instr=0, PC unchanged.
  - Next cycle without flush → normal capture resumes.
- Wrap: run to PC=8'hFC.
  - Required: next A=8'h00, id_pc=FC then 00.
- Halt and mid-run reset: halt at PC=24.
  - Required: id_pc=24 valid, then fetch_state=2 with id_valid=0 forever.
  - Reset → A=0, fetch_state=0, id_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end and the
// instruction memory it drives.
package fetch_pkg;

  // Default widths, shared with instruction_memory (byte address A, word I)
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  // Word placed into IF/ID whenever the slot carries no real instruction
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  // Byte distance between consecutive instructions
  localparam int INSTR_STRIDE = 4;

  // Fetch controller states; encodings are visible on fetch_state
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_npc_reg.sv
// PC/nPC register pair with delayed-branch sequencing.
// On advance, PC takes the old nPC (so the delay slot is always fetched)
// and nPC takes either the word-aligned branch target or nPC+stride.
module pc_npc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_advance,
  input  logic              i_br_taken,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(INSTR_STRIDE);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_npc;
  logic [ADDR_W-1:0] w_target_aligned;
  logic [ADDR_W-1:0] w_npc_seq;
  logic [ADDR_W-1:0] w_npc_next;

  // Targets are forced onto a word boundary; the sequential increment
  // simply wraps at the top of the address space.
  assign w_target_aligned = {i_br_target[ADDR_W-1:2], 2'b00};
  assign w_npc_seq        = r_npc + STRIDE;
  assign w_npc_next       = i_br_taken ? w_target_aligned : w_npc_seq;

  // PC/nPC update: reset load, otherwise step only when advance is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_npc <= RESET_PC + STRIDE;
    end else if (i_advance) begin
      r_pc  <= r_npc;
      r_npc <= w_npc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: drives instruction_memory from the PC
// register, captures the returned word into the IF/ID register and
// sequences boot bubble, normal fetch, stall, nullify and halt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] I,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic [1:0]        fetch_state
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;

  logic [ADDR_W-1:0] w_pc;
  logic              w_advance;

  logic              w_if_load;
  logic [DATA_W-1:0] w_if_instr;
  logic [ADDR_W-1:0] w_if_pc;
  logic              w_if_valid;

  logic [DATA_W-1:0] r_id_instr;
  logic [ADDR_W-1:0] r_id_pc;
  logic              r_id_valid;

  pc_npc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_npc (
    .clk         (clk),
    .reset       (reset),
    .i_advance   (w_advance),
    .i_br_taken  (br_taken),
    .i_br_target (br_target),
    .o_pc        (w_pc)
  );

  // State register; reset always returns to the boot bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, PC advance enable and IF/ID load selection.
  // Stall freezes everything in RUN except a nullify of IF/ID; branch and
  // halt requests are only acted on in a non-stalled RUN cycle. The halt
  // cycle still captures the instruction at PC but does not advance.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_if_load    = 1'b0;
    w_if_instr   = NOP_WORD;
    w_if_pc      = w_pc;
    w_if_valid   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_if_load    = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          w_if_load = 1'b1;
          if (!flush) begin
            w_if_instr = I;
            w_if_valid = 1'b1;
          end
          if (halt) begin
            w_state_next = ST_HALTED;
          end else begin
            w_advance = 1'b1;
          end
        end else if (flush) begin
          w_if_load = 1'b1;
        end
      end
      ST_HALTED: begin
        w_if_load = 1'b1;
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  // IF/ID pipeline register; holds its contents when no load is selected
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_instr <= NOP_WORD;
      r_id_pc    <= '0;
      r_id_valid <= 1'b0;
    end else if (w_if_load) begin
      r_id_instr <= w_if_instr;
      r_id_pc    <= w_if_pc;
      r_id_valid <= w_if_valid;
    end
  end

  assign A           = w_pc;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_valid    = r_id_valid;
  assign fetch_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a behavioural fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken, halt;
  logic [7:0]  br_target;
  logic [7:0]  A;
  logic [31:0] I;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic [1:0]  fetch_state;

  logic [31:0] mem [256];
  assign I = mem[A];

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt        (halt),
    .A           (A),
    .I           (I),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .fetch_state (fetch_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Behavioural model: 0 boot, 1 run, 2 halted
  logic [1:0]  m_state;
  logic [7:0]  m_pc, m_npc, e_pc;
  logic [31:0] e_instr;
  logic        e_valid;

  logic [50:0] obs;
  assign obs = {A, id_instr, id_pc, id_valid, fetch_state};

  function automatic logic [50:0] exp_vec();
    return {m_pc, e_instr, e_pc, e_valid, m_state};
  endfunction

  // One clock: apply inputs, step the model from pre-edge values, wait.
  task automatic tick(input logic s, input logic f, input logic b,
                      input logic [7:0] t, input logic h, input logic r);
    logic [7:0] old_npc;
    stall = s; flush = f; br_taken = b; br_target = t; halt = h; reset = r;
    if (r) begin
      m_state = 2'd0; m_pc = 8'h00; m_npc = 8'h04;
      e_instr = 32'h0; e_pc = 8'h00; e_valid = 1'b0;
    end else if (m_state == 2'd0) begin
      e_instr = 32'h0; e_valid = 1'b0; e_pc = m_pc; m_state = 2'd1;
    end else if (m_state == 2'd2) begin
      e_instr = 32'h0; e_valid = 1'b0; e_pc = m_pc;
    end else if (s) begin
      if (f) begin e_instr = 32'h0; e_valid = 1'b0; e_pc = m_pc; end
    end else begin
      e_pc = m_pc;
      if (f) begin e_instr = 32'h0; e_valid = 1'b0; end
      else   begin e_instr = mem[m_pc]; e_valid = 1'b1; end
      if (h) m_state = 2'd2;
      else begin
        old_npc = m_npc;
        m_npc = b ? (t & 8'hFC) : (m_npc + 8'd4);
        m_pc  = old_npc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc=%0d rst=%0b stl=%0b fl=%0b br=%0b tg=%02h hlt=%0b | A=%02h id_pc=%02h id_instr=%08h v=%0b st=%0d",
             cyc, r, s, f, b, t, h, A, id_pc, id_instr, id_valid, fetch_state);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 8'h00, 0, 1);
      tests++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec());
      end
      tests++;
      if ({A, fetch_state, id_valid, id_instr} !== {8'h00, 2'd0, 1'b0, 32'h0}) begin
        fails++; $display("FAIL reset_state A=%h st=%0d v=%0b instr=%h exp A=00 st=0 v=0 instr=0",
                          A, fetch_state, id_valid, id_instr);
      end
    end
  endtask

  task automatic test_free_run();
    logic [7:0] k;
    tick(0, 0, 0, 8'h00, 0, 0);
    tests++;
    if ({id_valid, fetch_state, A} !== {1'b0, 2'd1, 8'h00}) begin
      fails++; $display("FAIL boot_bubble v=%0b st=%0d A=%h exp v=0 st=1 A=00", id_valid, fetch_state, A);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 8'h00, 0, 0);
      k = 8'(i * 4);
      tests++;
      if ({id_pc, id_instr, id_valid} !== {k, 32'hA000_0000 | {24'h0, k}, 1'b1}) begin
        fails++; $display("FAIL free_run id_pc=%h instr=%h v=%0b exp id_pc=%h instr=%h v=1",
                          id_pc, id_instr, id_valid, k, 32'hA000_0000 | {24'h0, k});
      end
      tests++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL free_run_model got=%h exp=%h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_branch();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'd8; exp_pc[1] = 8'd12; exp_pc[2] = 8'd64; exp_pc[3] = 8'd68;
    tick(0, 0, 0, 8'h00, 0, 1);
    tick(0, 0, 0, 8'h00, 0, 0);
    tick(0, 0, 0, 8'h00, 0, 0);
    tick(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, (i == 0), 8'h41, 0, 0);
      tests++;
      if ({id_pc, id_valid} !== {exp_pc[i], 1'b1}) begin
        fails++; $display("FAIL branch_seq step=%0d id_pc=%h v=%0b exp id_pc=%h v=1", i, id_pc, id_valid, exp_pc[i]);
      end
      tests++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL branch_model got=%h exp=%h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    tick(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 8'h00, 0, 0);
    // PC=16, IF/ID holds 12; branch and halt requests must be ignored
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 1, 8'h80, 1, 0);
      tests++;
      if ({A, id_pc, id_instr, id_valid, fetch_state} !== {8'd16, 8'd12, 32'hA000_000C, 1'b1, 2'd1}) begin
        fails++; $display("FAIL stall_hold A=%h id_pc=%h instr=%h v=%0b st=%0d exp A=10 id_pc=0c instr=a000000c v=1 st=1",
                          A, id_pc, id_instr, id_valid, fetch_state);
      end
    end
    tick(0, 0, 0, 8'h00, 0, 0);
    tests++;
    if ({id_pc, A} !== {8'd16, 8'd20}) begin
      fails++; $display("FAIL stall_release1 id_pc=%h A=%h exp id_pc=10 A=14", id_pc, A);
    end
    tick(0, 0, 0, 8'h00, 0, 0);
    tests++;
    if ({id_pc, A} !== {8'd20, 8'd24}) begin
      fails++; $display("FAIL stall_release2 id_pc=%h A=%h exp id_pc=14 A=18", id_pc, A);
    end
    tests++;
    if (obs !== exp_vec()) begin
      fails++; $display("FAIL stall_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_flush_stall();
    // continues from PC=24
    tick(1, 1, 0, 8'h00, 0, 0);
    tests++;
    if ({id_valid, id_instr, A} !== {1'b0, 32'h0, 8'd24}) begin
      fails++; $display("FAIL flush_stall v=%0b instr=%h A=%h exp v=0 instr=0 A=18", id_valid, id_instr, A);
    end
    tick(0, 0, 0, 8'h00, 0, 0);
    tests++;
    if ({id_pc, id_instr, id_valid, A} !== {8'd24, 32'hA000_0018, 1'b1, 8'd28}) begin
      fails++; $display("FAIL flush_resume id_pc=%h instr=%h v=%0b A=%h exp 18 a0000018 1 1c",
                        id_pc, id_instr, id_valid, A);
    end
    tests++;
    if (obs !== exp_vec()) begin
      fails++; $display("FAIL flush_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 0, 8'h00, 0, 1);
    tick(0, 0, 0, 8'h00, 0, 0);
    tick(0, 0, 1, 8'hFC, 0, 0);
    tick(0, 0, 0, 8'h00, 0, 0);
    tests++;
    if (A !== 8'hFC) begin
      fails++; $display("FAIL wrap_reach A=%h exp fc", A);
    end
    tick(0, 0, 0, 8'h00, 0, 0);
    tests++;
    if ({id_pc, A} !== {8'hFC, 8'h00}) begin
      fails++; $display("FAIL wrap_edge id_pc=%h A=%h exp id_pc=fc A=00", id_pc, A);
    end
    tick(0, 0, 0, 8'h00, 0, 0);
    tests++;
    if ({id_pc, id_instr, A} !== {8'h00, 32'hA000_0000, 8'h04}) begin
      fails++; $display("FAIL wrap_after id_pc=%h instr=%h A=%h exp 00 a0000000 04", id_pc, id_instr, A);
    end
  endtask

  task automatic test_halt();
    tick(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 8'h00, 0, 0);
    tick(0, 0, 0, 8'h00, 1, 0);
    tests++;
    if ({id_pc, id_valid, fetch_state, A} !== {8'd24, 1'b1, 2'd2, 8'd24}) begin
      fails++; $display("FAIL halt_entry id_pc=%h v=%0b st=%0d A=%h exp 18 1 2 18", id_pc, id_valid, fetch_state, A);
    end
    for (int i = 0; i < 4; i++) begin
      tick(i[0], 0, 1, 8'h40, 0, 0);
      tests++;
      if ({id_valid, fetch_state, A, id_instr} !== {1'b0, 2'd2, 8'd24, 32'h0}) begin
        fails++; $display("FAIL halted v=%0b st=%0d A=%h instr=%h exp v=0 st=2 A=18 instr=0",
                          id_valid, fetch_state, A, id_instr);
      end
    end
    tick(0, 0, 0, 8'h00, 0, 1);
    tests++;
    if ({A, fetch_state, id_valid} !== {8'h00, 2'd0, 1'b0}) begin
      fails++; $display("FAIL halt_reset A=%h st=%0d v=%0b exp 00 0 0", A, fetch_state, id_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    tick(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(5) == 0),
           8'($urandom), ($urandom_range(39) == 0), ($urandom_range(63) == 0));
      tests++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; halt = 1'b0; br_target = 8'h00;
    m_state = 2'd0; m_pc = 8'h00; m_npc = 8'h04; e_pc = 8'h00; e_instr = 32'h0; e_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    test_reset();
    test_free_run();
    test_branch();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
